// File: rtl/ahb_dma_src_fifo.sv
// AHB-Lite DMA source: producer-filled word FIFO drained by burst reads, with DmacReq handshake.
// Latency: CSR and non-empty window reads complete with zero wait states; a pushed word is readable the next cycle.
// Backpressure: empty-window reads stall up to TIMEOUT cycles then ERROR; push_ready drops when full (overflow is sticky).
module ahb_dma_src_fifo #(
  parameter int DEPTH      = 16,
  parameter int THRESH_RST = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  input  logic        push_valid,
  input  logic [31:0] push_data,
  output logic        push_ready,
  output logic        DmacReq,
  input  logic        ReqAck,
  output logic        irq_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [9:0]    A_STATUS = 10'h200;
  localparam logic [9:0]    A_THRESH = 10'h201;
  localparam logic [9:0]    A_CTRL   = 10'h202;
  localparam logic [7:0]    TO_LIM   = 8'(TIMEOUT);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {REQ_IDLE, REQ_REQ, REQ_ACKD} req_state_e;

  // Storage and FIFO bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Control registers
  logic [LW-1:0] thresh_q, thresh_d;
  logic          en_q, en_d;

  // AHB data-phase tracking
  logic          dp_q, dp_d;
  logic          dp_wr_q, dp_wr_d;
  logic [9:0]    dp_addr_q, dp_addr_d;
  logic          err2_q, err2_d;
  logic [7:0]    wcnt_q, wcnt_d;

  req_state_e    req_q, req_d;

  logic          empty, full, addr_ph, dp_win, pop, push_acc, flush, csr_wr;
  logic          hready_c;
  logic [1:0]    hresp_c;
  logic [31:0]   hrdata_c;
  logic [8:0]    thr_wr;

  // Only word transfers exist, so size, byte offset and the upper address bits carry no information
  logic          unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:12], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign addr_ph = HSEL & HTRANS[1] & HREADYIN;
  assign dp_win  = ~dp_addr_q[9];
  assign thr_wr  = {1'b0, HWDATA[7:0]};
  assign flush   = csr_wr && (dp_addr_q == A_CTRL) && HWDATA[1];
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign push_acc = push_valid & (~full | pop);

  // Data-phase response: read data, wait states, two-cycle ERROR and pop request
  always_comb begin
    hready_c = 1'b1;
    hresp_c  = 2'b00;
    hrdata_c = 32'h0;
    pop      = 1'b0;
    err2_d   = 1'b0;
    wcnt_d   = 8'h0;
    csr_wr   = 1'b0;
    if (dp_q) begin
      if (err2_q) begin
        hresp_c = 2'b01;
      end else if (dp_win) begin
        if (dp_wr_q) begin
          hready_c = 1'b0;
          hresp_c  = 2'b01;
          err2_d   = 1'b1;
        end else if (!empty) begin
          hrdata_c = mem_q[rd_ptr_q];
          pop      = 1'b1;
        end else if (wcnt_q >= TO_LIM) begin
          hready_c = 1'b0;
          hresp_c  = 2'b01;
          err2_d   = 1'b1;
        end else begin
          hready_c = 1'b0;
          wcnt_d   = wcnt_q + 8'd1;
        end
      end else begin
        csr_wr = dp_wr_q;
        if (!dp_wr_q) begin
          case (dp_addr_q)
            A_STATUS: hrdata_c = 32'({level_q, 5'b0, ovf_q, full, empty});
            A_THRESH: hrdata_c = 32'(thresh_q);
            A_CTRL:   hrdata_c = {31'b0, en_q};
            default:  hrdata_c = 32'h0;
          endcase
        end
      end
    end
  end

  // Keep the data phase open while stalled; otherwise take the next address phase
  always_comb begin
    dp_d      = dp_q;
    dp_wr_d   = dp_wr_q;
    dp_addr_d = dp_addr_q;
    if (!(dp_q && !hready_c)) begin
      dp_d      = addr_ph;
      dp_wr_d   = HWRITE;
      dp_addr_d = HADDR[11:2];
    end
  end

  // CSR writes; THRESH is clamped into 1..DEPTH
  always_comb begin
    en_d     = en_q;
    thresh_d = thresh_q;
    if (csr_wr && dp_addr_q == A_CTRL) begin
      en_d = HWDATA[0];
    end
    if (csr_wr && dp_addr_q == A_THRESH) begin
      if (thr_wr == 9'd0)             thresh_d = LW'(1);
      else if (thr_wr > 9'(DEPTH))    thresh_d = LVL_FULL;
      else                            thresh_d = LW'(thr_wr);
    end
  end

  // FIFO pointers, level and sticky overflow; flush overrides any push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_acc) - LW'(pop);
      if (push_valid && full && !pop) ovf_d = 1'b1;
    end
  end

  // DMA request handshake; disable always returns to IDLE
  always_comb begin
    req_d = req_q;
    if (!en_q) begin
      req_d = REQ_IDLE;
    end else begin
      case (req_q)
        REQ_IDLE: if (level_q >= thresh_q) req_d = REQ_REQ;
        REQ_REQ: begin
          if (flush)       req_d = REQ_IDLE;
          else if (ReqAck) req_d = REQ_ACKD;
        end
        REQ_ACKD: if (!ReqAck) req_d = REQ_IDLE;
        default:  req_d = REQ_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      thresh_q  <= LW'(THRESH_RST);
      en_q      <= 1'b0;
      dp_q      <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      err2_q    <= 1'b0;
      wcnt_q    <= 8'h0;
      req_q     <= REQ_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      thresh_q  <= thresh_d;
      en_q      <= en_d;
      dp_q      <= dp_d;
      dp_wr_q   <= dp_wr_d;
      dp_addr_q <= dp_addr_d;
      err2_q    <= err2_d;
      wcnt_q    <= wcnt_d;
      req_q     <= req_d;
    end
  end

  // Word storage; contents need no reset since level gates visibility
  always_ff @(posedge HCLK) begin
    if (push_acc && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign HRDATA     = hrdata_c;
  assign HREADYOUT  = hready_c;
  assign HRESP      = hresp_c;
  assign push_ready = ~full;
  assign DmacReq    = (req_q == REQ_REQ);
  assign irq_ovf    = ovf_q;

endmodule
